// File: rtl/debug_io_pkg.sv
// Shared types and sizing helpers for the board debug I/O blocks.
package debug_io_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } btn_state_t;

  localparam int unsigned DEBOUNCE_DEFAULT   = 500000;
  localparam int unsigned LONG_PRESS_DEFAULT = 50000000;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    if (max_val < 32'd2) return 32'd1;
    return $clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin; reset value selectable.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debug_button_reader.sv
// Debounces the active-low debug button into a level, press/release/long-press pulses and a press counter.
// Optional DEBUG_BTN_LED_ECHO_EN adds btn_echo_led, which blinks while a long press is held.
module debug_button_reader
  import debug_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_DEFAULT,
  parameter int unsigned COUNT_W           = 8
) (
  input  logic               clk_50,
  input  logic               resetn,
  input  logic               debug_btn_n,
  input  logic               clear_count,
  output logic               btn_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_press_pulse,
  output logic [COUNT_W-1:0] press_count
`ifdef DEBUG_BTN_LED_ECHO_EN
  ,
  output logic               btn_echo_led
`endif
);

  localparam int unsigned   DW        = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned   HW        = cnt_w(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_PRESS_CYCLES - 2);

  btn_state_t    state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          btn_n_sync, pressed_s;
  logic          level_d, press_c, release_c, long_c;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk_50),
    .rst_n (resetn),
    .d     (debug_btn_n),
    .q     (btn_n_sync)
  );

  assign pressed_s = ~btn_n_sync;

  // Debounce FSM plus hold timer; a pending state counts consecutive agreeing samples.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    hold_d    = hold_q;
    press_c   = 1'b0;
    release_c = 1'b0;
    long_c    = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (pressed_s) begin
          state_d   = ST_PRESS_PEND;
          deb_cnt_d = DW'(1);
        end
      end
      ST_PRESS_PEND: begin
        if (!pressed_s) begin
          state_d   = ST_RELEASED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = ST_PRESSED;
          deb_cnt_d = '0;
          press_c   = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      ST_PRESSED: begin
        if (!pressed_s) begin
          state_d   = ST_RELEASE_PEND;
          deb_cnt_d = DW'(1);
        end
      end
      ST_RELEASE_PEND: begin
        if (pressed_s) begin
          state_d   = ST_PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = ST_RELEASED;
          deb_cnt_d = '0;
          release_c = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d   = ST_RELEASED;
        deb_cnt_d = '0;
      end
    endcase

    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_PEND);

    // Hold timer saturates at its last value so the long-press event fires once per press.
    if (press_c) begin
      hold_d = '0;
    end else if (level_d && (hold_q < HOLD_LAST)) begin
      hold_d = hold_q + HW'(1);
      long_c = (hold_q == HOLD_PRE);
    end
  end

  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ST_RELEASED;
      deb_cnt_q        <= '0;
      hold_q           <= '0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      press_count      <= '0;
    end else begin
      state_q          <= state_d;
      deb_cnt_q        <= deb_cnt_d;
      hold_q           <= hold_d;
      btn_level        <= level_d;
      press_pulse      <= press_c;
      release_pulse    <= release_c;
      long_press_pulse <= long_c;
      if (clear_count) begin
        press_count <= '0;
      end else if (press_c) begin
        press_count <= press_count + COUNT_W'(1);
      end
    end
  end

`ifdef DEBUG_BTN_LED_ECHO_EN
  localparam int unsigned BLINK_W = 22;

  logic [BLINK_W-1:0] blink_q;
  logic               long_active_q;

  // LED mirrors the level, but toggles on each blink-counter wrap once a long press is active.
  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn) begin
      blink_q       <= '0;
      long_active_q <= 1'b0;
      btn_echo_led  <= 1'b0;
    end else begin
      blink_q <= blink_q + BLINK_W'(1);
      if (!level_d) begin
        long_active_q <= 1'b0;
      end else if (long_c) begin
        long_active_q <= 1'b1;
      end
      if (long_active_q && level_d) begin
        if (&blink_q) btn_echo_led <= ~btn_echo_led;
      end else begin
        btn_echo_led <= level_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_debug_button_reader.sv
// Randomized and directed bench for debug_button_reader against a run-length debounce model.
module tb_debug_button_reader;

  localparam int unsigned D  = 4;
  localparam int unsigned L  = 16;
  localparam int unsigned CW = 8;

  logic          clk_50;
  logic          resetn;
  logic          debug_btn_n;
  logic          clear_count;
  logic          btn_level;
  logic          press_pulse;
  logic          release_pulse;
  logic          long_press_pulse;
  logic [CW-1:0] press_count;
`ifdef DEBUG_BTN_LED_ECHO_EN
  logic          btn_echo_led;
`endif

  debug_button_reader #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .COUNT_W           (CW)
  ) dut (
    .clk_50           (clk_50),
    .resetn           (resetn),
    .debug_btn_n      (debug_btn_n),
    .clear_count      (clear_count),
    .btn_level        (btn_level),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse),
    .press_count      (press_count)
`ifdef DEBUG_BTN_LED_ECHO_EN
    ,
    .btn_echo_led     (btn_echo_led)
`endif
  );

  initial begin
    clk_50 = 1'b0;
    forever #5 clk_50 = ~clk_50;
  end

  int n_cmp = 0;
  int n_err = 0;
  int obs_pp = 0;
  int obs_rp = 0;
  int obs_lp = 0;

  // Reference: pin history delay line, level flips after D consecutive disagreeing samples.
  bit m_h0, m_h1;
  bit m_lvl, m_pp, m_rp, m_lp;
  int m_run, m_held, m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_h0 = 1'b1; m_h1 = 1'b1;
    m_lvl = 1'b0; m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
    m_run = 0; m_held = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input bit pin, input bit clr);
    bit s;
    s = !m_h1;
    m_h1 = m_h0;
    m_h0 = pin;
    m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
    m_run = (s != m_lvl) ? m_run + 1 : 0;
    if (m_run == int'(D)) begin
      m_lvl = !m_lvl;
      m_run = 0;
      if (m_lvl) m_pp = 1'b1;
      else       m_rp = 1'b1;
    end
    if (m_pp) begin
      m_held = 0;
    end else if (m_lvl && m_held < int'(L) - 1) begin
      m_held++;
      if (m_held == int'(L) - 1) m_lp = 1'b1;
    end
    if (clr)       m_cnt = 0;
    else if (m_pp) m_cnt = (m_cnt + 1) % (1 << CW);
  endfunction

  function automatic logic [11:0] dut_vec();
    return {btn_level, press_pulse, release_pulse, long_press_pulse, press_count};
  endfunction

  function automatic logic [11:0] model_vec();
    return {m_lvl, m_pp, m_rp, m_lp, 8'(m_cnt)};
  endfunction

  // One clock: drive inputs, advance model, compare every output.
  task automatic tick(input logic pin, input logic clr);
    debug_btn_n = pin;
    clear_count = clr;
    @(posedge clk_50);
    #1;
    if (!resetn) model_reset();
    else         model_step(pin, clr);
    obs_pp += int'(press_pulse);
    obs_rp += int'(release_pulse);
    obs_lp += int'(long_press_pulse);
    check_eq("cycle_outputs", 32'(dut_vec()), 32'(model_vec()));
  endtask

  // Hold the pin and count clocks until the selected pulse is seen (bounded).
  task automatic run_until(input int sel, input logic pin, input int limit, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      tick(pin, 1'b0);
      n++;
      case (sel)
        0:       hit = press_pulse;
        1:       hit = release_pulse;
        default: hit = long_press_pulse;
      endcase
    end
  endtask

  int n;
  int base;
  logic lv;
  int dur;

  initial begin
    resetn = 1'b0;
    debug_btn_n = 1'b1;
    clear_count = 1'b0;
    model_reset();
    #2;
    check_eq("reset_state", 32'(dut_vec()), 32'd0);
    resetn = 1'b1;

    // Clean press after 9 idle cycles, then clean release.
    repeat (9) tick(1'b1, 1'b0);
    run_until(0, 1'b0, 20, n);
    check_eq("press_latency", n, D + 2);
    repeat (4) tick(1'b0, 1'b0);
    check_eq("first_count", 32'(press_count), 32'd1);
    run_until(1, 1'b1, 20, n);
    check_eq("release_latency", n, D + 2);
    repeat (4) tick(1'b1, 1'b0);

    // Short bounces must be rejected entirely.
    base = obs_pp + obs_rp + obs_lp;
    repeat (5) begin
      repeat (3) tick(1'b0, 1'b0);
      repeat (5) tick(1'b1, 1'b0);
    end
    check_eq("bounce_pulses", obs_pp + obs_rp + obs_lp - base, 0);
    check_eq("bounce_level", 32'(btn_level), 32'd0);

    // 40-cycle hold: exactly one long press, L-1 cycles after the press pulse.
    run_until(0, 1'b0, 20, n);
    check_eq("hold_press_latency", n, D + 2);
    run_until(2, 1'b0, 30, n);
    check_eq("long_press_delay", n, L - 1);
    base = obs_lp;
    repeat (40 - (D + 2) - (L - 1)) tick(1'b0, 1'b0);
    check_eq("long_press_no_repeat", obs_lp - base, 0);
    run_until(1, 1'b1, 20, n);
    check_eq("hold_release_latency", n, D + 2);
    repeat (4) tick(1'b1, 1'b0);

    // Counter wrap after 256 presses, then clear colliding with a press pulse.
    tick(1'b1, 1'b1);
    repeat (256) begin
      repeat (8) tick(1'b0, 1'b0);
      repeat (8) tick(1'b1, 1'b0);
    end
    check_eq("count_wrap", 32'(press_count), 32'd0);
    repeat (8) tick(1'b0, 1'b0);
    repeat (8) tick(1'b1, 1'b0);
    check_eq("count_one", 32'(press_count), 32'd1);
    repeat (D + 1) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check_eq("clear_press_pulse", 32'(press_pulse), 32'd1);
    check_eq("clear_priority", 32'(press_count), 32'd0);

    // Reset while held: outputs drop at once, then a fresh debounced press.
    repeat (3) tick(1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    model_reset();
    check_eq("async_reset", 32'(dut_vec()), 32'd0);
    repeat (2) tick(1'b0, 1'b0);
    resetn = 1'b1;
    run_until(0, 1'b0, 20, n);
    check_eq("post_reset_press", n, D + 2);
    repeat (8) tick(1'b1, 1'b0);

    // Random bouncy activity with occasional clears.
    repeat (150) begin
      lv  = 1'($urandom_range(0, 1));
      dur = int'($urandom_range(1, 24));
      repeat (dur) tick(lv, 1'($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debug_button_reader.md
Name: debug_button_reader

Overview:
- Input-side counterpart of the board's debug LED blinker: reads the raw, bouncy debug push-button pin instead of driving a pin.
- Synchronizes, debounces and classifies button activity into a clean level plus single-cycle press, release and long-press events.
- Also keeps a wrapping press counter.
- Sits at the top level next to the LED logic; its outputs feed debug registers and mode-select logic in the 50 MHz domain.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz); legal range >= 2.
- LONG_PRESS_CYCLES, 50000000: cycles the debounced level must stay pressed before a long-press event (1 s); must exceed DEBOUNCE_CYCLES.
- COUNT_W, 8: width of press_count.

Ports:
- clk_50  in  1  system clock, 50 MHz; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset; asserts asynchronously, deasserts synchronously to clk_50 upstream.
- debug_btn_n  in  1  raw button pin, asynchronous, active-low (pull-up; 0 = pressed).
- clear_count  in  1  synchronous, one-cycle request to zero press_count.
- btn_level  out  1  debounced state, 1 = pressed.
- press_pulse  out  1  one-cycle pulse on accepted press.
- release_pulse  out  1  one-cycle pulse on accepted release.
- long_press_pulse  out  1  one-cycle pulse when the hold reaches LONG_PRESS_CYCLES.
- press_count  out  COUNT_W  number of accepted presses, modulo 2^COUNT_W.

Behaviour:
- Reset values:
  - btn_level = 0; all pulses = 0; press_count = 0.
  - Both synchronizer flops = 1 (released).
  - FSM = RELEASED; debounce and hold counters = 0.
- Input path: 2-flop synchronizer on debug_btn_n; s = inverted output of the second flop (1 = pressed). Nothing else samples the raw pin.
- FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  - RELEASED, s=1: go to PRESS_PEND, debounce counter = 1.
  - PRESS_PEND:
    - s=1: counter increments.
    - When counter reaches DEBOUNCE_CYCLES with s=1: go to PRESSED, counter = 0.
    - s=0 at any point (bounce): return to RELEASED, counter = 0, no pulse.
  - PRESSED, s=0: go to RELEASE_PEND, counter = 1.
  - RELEASE_PEND: mirror of PRESS_PEND; accept goes to RELEASED, bounce returns to PRESSED without a pulse.
- Outputs are registered.
  - btn_level rises in the same cycle PRESSED is entered; press_pulse is high for exactly that cycle.
  - Release is symmetric: btn_level falls and release_pulse is high for the cycle RELEASED is entered.
  - Clean pin edge to pulse: DEBOUNCE_CYCLES + 2 clocks, with +1 clock of synchronizer uncertainty.
- Long press:
  - Hold counter clears on entry to PRESSED and increments every cycle in PRESSED or RELEASE_PEND.
  - long_press_pulse fires once, when the hold counter equals LONG_PRESS_CYCLES - 1.
  - The counter then saturates: no repeat for the same press.
  - A rejected release bounce does not restart the hold count.
- press_count increments on press_pulse and wraps from 2^COUNT_W - 1 to 0.
  - clear_count has priority: if clear_count and press_pulse coincide, the result is 0.
- Pulses are mutually exclusive by construction; never two in one cycle.
- Reset mid-operation: everything returns to reset values immediately.
  - If the button is still held after reset, a fresh debounce runs and press_pulse is generated. This is intended.

Optional Feature:
- Macro: DEBUG_BTN_LED_ECHO_EN.
- Defined:
  - Extra output port btn_echo_led (1 bit), reset value 0.
  - Follows btn_level, except it blinks (toggles every 2^22 cycles via a free-running counter) while a long press is active, i.e. after long_press_pulse until release.
- Undefined: the port and blink counter are absent; all other behaviour is identical.

Decomposition:
- Package debug_io_pkg holds:
  - the btn_state_t enum (four states);
  - DEBOUNCE_DEFAULT = 500000 and LONG_PRESS_DEFAULT = 50000000;
  - counter width functions based on $clog2.
- One sub-module, sync_2ff: 1-bit, reset value as a parameter, async active-low reset. It is reused for other board pins later.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, COUNT_W=8):
- Pin low at cycle 10, held -> press_pulse high exactly one cycle at cycle 16 (±1); btn_level 1 from then; press_count = 1.
- Pin low for 3 cycles then high, repeated 5 times -> no pulses, btn_level stays 0, press_count stays 0.
- Press held 40 cycles -> one long_press_pulse 15 cycles after press_pulse; none after; on release, release_pulse one cycle, DEBOUNCE_CYCLES+2 after the pin rises.
- 256 clean presses -> press_count wraps to 0. On a later press, assert clear_count in the press_pulse cycle -> press_count = 0.
- resetn low for 2 cycles while in PRESSED with pin still low -> outputs 0 during reset; after release of reset, press_pulse again after 4+2 cycles.
- With DEBUG_BTN_LED_ECHO_EN: btn_echo_led follows btn_level and blinks after long press. Without it: the port is absent and compile is clean.
